pipeline_fetch_unit: RTL and testbench
======================================

PIPELINE_FETCH_UNIT -- requirements
Module: pipeline_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be zero).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 fetch_en  input  1  from halt control; 0 = decode stage stalled, fetched_* SHALL hold.
REQ-005 jmpctrl_en  input  1  one-cycle redirect strobe from halt control (JALR resolved).
REQ-006 jmp_target  input  32  redirect address, valid when jmpctrl_en=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_ack  input  1  memory completes current request this cycle; ignored when imem_req=0.
REQ-010 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-011 fetched_instr  output  32  registered instruction to decoded latch.
REQ-012 fetched_pc  output  32  registered address of fetched_instr.
REQ-013 fetched_valid  output  1  registered; 1 = fetched_instr/fetched_pc hold a real instruction, 0 = bubble.

Function
REQ-014 The block SHALL implement states FETCH, HOLD, FLUSH; state, pc, hold buffer and fetched_* SHALL be registers.
REQ-015 imem_req SHALL be 1 in FETCH and FLUSH, 0 in HOLD; imem_addr SHALL equal pc in FETCH/HOLD and flush_addr in FLUSH.
REQ-016 Once imem_req=1, imem_addr SHALL remain stable until the cycle imem_ack=1 (response may arrive the same cycle as the request).
REQ-017 FETCH, imem_ack=1, fetch_en=1, jmpctrl_en=0: fetched_instr<=imem_rdata, fetched_pc<=pc, fetched_valid<=1, pc<=pc+4, stay FETCH.
REQ-018 FETCH, imem_ack=0, fetch_en=1, jmpctrl_en=0: fetched_valid<=0 (bubble), fetched_instr/fetched_pc unchanged, stay FETCH.
REQ-019 FETCH, imem_ack=1, fetch_en=0, jmpctrl_en=0: capture {imem_rdata, pc} into hold buffer, pc<=pc+4, fetched_* unchanged, go HOLD.
REQ-020 FETCH, imem_ack=0, fetch_en=0, jmpctrl_en=0: fetched_* unchanged, request held, stay FETCH.
REQ-021 HOLD, fetch_en=1, jmpctrl_en=0: fetched_* <= hold buffer, fetched_valid<=1, go FETCH; HOLD, fetch_en=0: no change.
REQ-022 jmpctrl_en=1 SHALL take priority over fetch_en and imem_ack: pc<={jmp_target[31:2],2'b00}, fetched_valid<=0, hold buffer discarded.
REQ-023 jmpctrl_en=1 in FETCH with imem_ack=0 (outstanding request): flush_addr<=current imem_addr, go FLUSH.
REQ-024 jmpctrl_en=1 in FETCH with imem_ack=1, in HOLD, or in FLUSH with imem_ack=1: response (if any) discarded, go FETCH.
REQ-025 FLUSH, imem_ack=1, jmpctrl_en=0: discard imem_rdata, go FETCH; FLUSH, imem_ack=0: stay FLUSH; fetched_valid SHALL stay 0 throughout FLUSH.
REQ-026 jmpctrl_en=1 in FLUSH with imem_ack=0: pc updated to new target, stay FLUSH, flush_addr unchanged.
REQ-027 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 Fetch-to-output latency SHALL be 1 cycle: data acked in cycle N appears on fetched_* in cycle N+1 when fetch_en=1 in N.
REQ-029 No instruction SHALL be duplicated or dropped across any stall/release sequence without an intervening jump.

Reset
REQ-030 rst=1 at a clock edge SHALL set state=FETCH, pc=RESET_PC, fetched_valid=0, fetched_instr=32'h0000_0013 (NOP), fetched_pc=RESET_PC, hold buffer empty, regardless of state or outstanding request.
REQ-031 rst SHALL override fetch_en, jmpctrl_en and imem_ack; imem_req SHALL be 1 with imem_addr=RESET_PC in the first cycle after rst deasserts.
REQ-032 The instruction memory shares rst and SHALL drop any pending response on reset; no FLUSH is entered due to reset.

Verification
REQ-033 Reset, imem_ack=1 every cycle, fetch_en=1, mem[i]=i -> fetched_pc 0,4,8,... with fetched_instr mem values, fetched_valid=1 from 2nd cycle after reset.
REQ-034 fetch_en=0 for 3 cycles while ack arrives for pc=8 -> fetched_* frozen at pc=4, imem_req=0 in HOLD; on release fetched_pc=8 then 12, no gap or repeat.
REQ-035 imem_ack delayed 2 cycles, jmpctrl_en=1 with jmp_target=32'h100 in the first wait cycle -> imem_addr stays old until ack, data discarded, next request 32'h100, fetched_valid=0 until 32'h100 delivered.
REQ-036 jmpctrl_en=1 and fetch_en=0 same cycle in HOLD -> buffer discarded, next fetched_pc=32'h100 after release.
REQ-037 RESET_PC=32'hFFFF_FFF8, continuous ack -> fetched_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst asserted mid-FLUSH -> next cycle state FETCH, imem_addr=RESET_PC, fetched_valid=0.

Source files
------------

// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: issues word requests, absorbs decode stalls in
// a one-entry hold buffer, and drains outstanding requests after a redirect.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   fetch_en                    0 = decode stalled, fetched_* hold
//   jmpctrl_en, jmp_target      one-cycle redirect strobe and its address
//   imem_req, imem_addr         memory request and word-aligned address
//   imem_ack, imem_rdata        memory completion and instruction word
//   fetched_instr, fetched_pc   registered instruction and its address
//   fetched_valid               1 = real instruction, 0 = bubble
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        jmpctrl_en,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetched_instr,
  output logic [31:0] fetched_pc,
  output logic        fetched_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] flush_addr, flush_addr_d;
  slot_t       hold_q, hold_d;
  logic        hold_vld, hold_vld_d;
  slot_t       out_q, out_d;
  logic        out_vld, out_vld_d;

  logic [31:0] pc_inc;
  logic [31:0] jmp_pc;

  assign pc_inc = pc + 32'd4;
  assign jmp_pc = {jmp_target[31:2], 2'b00};

  // In FLUSH the request on the bus is the abandoned one; keep
  // presenting its address until the memory acks it.
  assign imem_req  = (state != HOLD);
  assign imem_addr = (state == FLUSH) ? flush_addr : pc;

  assign fetched_instr = out_q.instr;
  assign fetched_pc    = out_q.pc;
  assign fetched_valid = out_vld;

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    flush_addr_d = flush_addr;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld;
    out_d        = out_q;
    out_vld_d    = out_vld;
    unique case (state)
      FETCH: begin
        if (jmpctrl_en) begin
          pc_d       = jmp_pc;
          out_vld_d  = 1'b0;
          hold_vld_d = 1'b0;
          if (!imem_ack) begin
            flush_addr_d = pc;
            state_d      = FLUSH;
          end
        end else if (imem_ack && fetch_en) begin
          out_d     = '{instr: imem_rdata, pc: pc};
          out_vld_d = 1'b1;
          pc_d      = pc_inc;
        end else if (imem_ack) begin
          hold_d     = '{instr: imem_rdata, pc: pc};
          hold_vld_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = HOLD;
        end else if (fetch_en) begin
          out_vld_d = 1'b0;
        end
      end
      HOLD: begin
        if (jmpctrl_en) begin
          pc_d       = jmp_pc;
          out_vld_d  = 1'b0;
          hold_vld_d = 1'b0;
          state_d    = FETCH;
        end else if (fetch_en) begin
          out_d      = hold_q;
          out_vld_d  = hold_vld;
          hold_vld_d = 1'b0;
          state_d    = FETCH;
        end
      end
      FLUSH: begin
        out_vld_d = 1'b0;
        if (jmpctrl_en) begin
          pc_d = jmp_pc;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      flush_addr <= RESET_PC;
      hold_q     <= '{instr: NOP, pc: RESET_PC};
      hold_vld   <= 1'b0;
      out_q      <= '{instr: NOP, pc: RESET_PC};
      out_vld    <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      flush_addr <= flush_addr_d;
      hold_q     <= hold_d;
      hold_vld   <= hold_vld_d;
      out_q      <= out_d;
      out_vld    <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Bench for pipeline_fetch_unit: latency-configurable memory model and an
// in-order scoreboard of expected fetch addresses.
module tb_pipeline_fetch_unit;

  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        jmpctrl_en;
  logic [31:0] jmp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] fetched_instr;
  logic [31:0] fetched_pc;
  logic        fetched_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;

  always #5 clk = ~clk;

  pipeline_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .jmpctrl_en    (jmpctrl_en),
    .jmp_target    (jmp_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .fetched_instr (fetched_instr),
    .fetched_pc    (fetched_pc),
    .fetched_valid (fetched_valid)
  );

  assign w_rdata = w_addr ^ K;

  pipeline_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (1'b1),
    .jmpctrl_en    (1'b0),
    .jmp_target    (32'h0),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_req),
    .imem_rdata    (w_rdata),
    .fetched_instr (w_instr),
    .fetched_pc    (w_pc),
    .fetched_valid (w_valid)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  bit          out_pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          consumed = 0;
  int          c0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic load_q(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++)
      exp_q.push_back((base & ~32'h3) + 32'(4 * i));
  endtask

  // One cycle, entered and left just after a falling edge.
  task automatic step(input logic fe, input logic j,
                      input logic [31:0] tgt);
    logic [31:0] e;
    logic        ack;
    if (out_pend) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, pend_addr);
    end
    ack = imem_req && (wait_cnt >= lat);
    imem_ack = ack;
    imem_rdata = ack ? (imem_addr ^ K) : 32'hDEAD_BEEF;
    fetch_en = fe;
    jmpctrl_en = j;
    jmp_target = tgt;
    if (fetched_valid && fe) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("sb_pc", fetched_pc, e);
      chk("sb_instr", fetched_instr, e ^ K);
      consumed++;
    end
    if (j) load_q(tgt);
    if (imem_req && !ack) begin
      wait_cnt++;
      out_pend = 1'b1;
      pend_addr = imem_addr;
    end else begin
      wait_cnt = 0;
      out_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with every other input pushing the other way.
  task automatic do_reset(input int n);
    rst = 1'b1;
    fetch_en = 1'b0;
    jmpctrl_en = 1'b1;
    jmp_target = 32'h80;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    jmpctrl_en = 1'b0;
    imem_ack = 1'b0;
    wait_cnt = 0;
    out_pend = 1'b0;
    load_q(32'h0);
    chk("rst_valid", {31'b0, fetched_valid}, 32'd0);
    chk("rst_instr", fetched_instr, 32'h0000_0013);
    chk("rst_pc", fetched_pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    jmpctrl_en = 1'b0;
    jmp_target = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;

    // Streaming with zero-latency memory; wrap instance alongside.
    do_reset(2);
    lat = 0;
    c0 = consumed;
    for (int i = 0; i < 20; i++) begin
      if (i >= 1 && i <= 3) begin
        chk("wrap_valid", {31'b0, w_valid}, 32'd1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * (i - 1)));
        chk("wrap_instr", w_instr, (32'hFFFF_FFF8 + 32'(4 * (i - 1))) ^ K);
      end
      step(1'b1, 1'b0, 32'h0);
    end
    chk("p1_count", 32'(consumed - c0), 32'd19);

    // Three-cycle decode stall while pc=8 is acked.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("p2_pc4", fetched_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    repeat (2) begin
      chk("p2_req", {31'b0, imem_req}, 32'd0);
      chk("p2_frozen", fetched_pc, 32'h4);
      chk("p2_fvalid", {31'b0, fetched_valid}, 32'd1);
      step(1'b0, 1'b0, 32'h0);
    end
    c0 = consumed;
    repeat (6) step(1'b1, 1'b0, 32'h0);
    chk("p2_count", 32'(consumed - c0), 32'd6);

    // Redirect while a slow request is outstanding.
    do_reset(1);
    lat = 2;
    step(1'b1, 1'b1, 32'h100);
    chk("p3_addr_old", imem_addr, 32'h0);
    chk("p3_bub1", {31'b0, fetched_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("p3_bub2", {31'b0, fetched_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("p3_new_req", imem_addr, 32'h100);
    chk("p3_bub3", {31'b0, fetched_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("p3_first_v", {31'b0, fetched_valid}, 32'd1);
    chk("p3_first", fetched_pc, 32'h100);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Redirect in HOLD with decode still stalled, then one from FETCH.
    do_reset(1);
    lat = 0;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("p4_hold_req", {31'b0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 32'h100);
    chk("p4_bub", {31'b0, fetched_valid}, 32'd0);
    chk("p4_addr", imem_addr, 32'h100);
    step(1'b0, 1'b0, 32'h0);
    chk("p4_bub2", {31'b0, fetched_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("p4_first", fetched_pc, 32'h100);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h203);
    c0 = consumed;
    repeat (5) step(1'b1, 1'b0, 32'h0);
    chk("p4_jmp_count", 32'(consumed - c0), 32'd4);

    // Redirect inside FLUSH, then reset in the middle of a FLUSH.
    do_reset(1);
    lat = 0;
    repeat (3) step(1'b1, 1'b0, 32'h0);
    lat = 3;
    step(1'b1, 1'b1, 32'h300);
    chk("p5_flush_addr", imem_addr, 32'hC);
    step(1'b1, 1'b1, 32'h400);
    chk("p5_flush_keep", imem_addr, 32'hC);
    chk("p5_bub", {31'b0, fetched_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("p5_redir", imem_addr, 32'h400);
    step(1'b1, 1'b1, 32'h500);
    chk("p5_flush2", imem_addr, 32'h400);
    step(1'b1, 1'b0, 32'h0);
    do_reset(1);

    // Mixed stalls and a late redirect with one-cycle memory.
    lat = 1;
    c0 = consumed;
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           (i == 20) ? 1'b1 : 1'b0, 32'h600);
    end
    chk("p6_progress", {31'b0, consumed > c0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
